// File: rtl/cp0_pkg.sv
// Shared definitions for the second-generation CP0: register map, exception
// codes, Status/Cause bit positions and the exception priority encoder.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [2:0] SEL_MAIN     = 3'd0;
  localparam logic [2:0] SEL_BADINSTR = 3'd1;

  typedef enum logic [4:0] {
    INT  = 5'h00,
    ADEL = 5'h04,
    ADES = 5'h05,
    SYS  = 5'h08,
    BP   = 5'h09,
    RI   = 5'h0A,
    OV   = 5'h0C
  } exc_code_t;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_ERL    = 2;
  localparam int ST_IM_LO  = 8;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;

  // Fixed priority: address errors first, break last.
  function automatic exc_code_t exc_priority(input logic ld, input logic st,
                                             input logic ov, input logic ri,
                                             input logic sys, input logic bp);
    if (ld)       return ADEL;
    else if (st)  return ADES;
    else if (ov)  return OV;
    else if (ri)  return RI;
    else if (sys) return SYS;
    else if (bp)  return BP;
    else          return INT;
  endfunction

endpackage

// File: rtl/cp0_prims.sv
// Generic datapath primitives shared across the core: an enabled register
// with synchronous reset and a two-input vector multiplexer.
module register #(
  parameter int             WIDTH       = 64,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clock) begin
    if (reset)       q <= RESET_VALUE;
    else if (enable) q <= d;
  end

endmodule

module mux2v #(
  parameter int WIDTH = 64
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? b : a;

endmodule

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled free-running Count, Compare match raising
// the sticky timer interrupt, cleared by any Compare write.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] wr_data,
  input  logic        wr_count,
  input  logic        wr_compare,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [31:0]   count_next;
  logic          count_changes;

  assign tick = (presc == PRESC_LAST);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    count_next    = count;
    count_changes = 1'b0;
    if (wr_count) begin
      count_next    = wr_data;
      count_changes = 1'b1;
    end else if (tick) begin
      count_next    = count + 32'd1;
      count_changes = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= '0;
      compare <= 32'hFFFF_FFFF;
      presc   <= '0;
      ti      <= 1'b0;
    end else begin
      count <= count_next;
      presc <= (wr_count || tick) ? '0 : presc + 1'b1;
      // A Compare write clears TI even if Count reaches the old Compare now.
      if (wr_compare) begin
        compare <= wr_data;
        ti      <= 1'b0;
      end else if (count_changes && (count_next == compare)) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_v2.sv
// Coprocessor 0, second generation: exception/interrupt arbitration, handler
// entry, Status/Cause/EPC/BadVAddr/BadInstr and the Count/Compare timer.
module cp0_v2
  import cp0_pkg::*;
#(
  parameter int         NUM_IRQ       = 6,
  parameter logic [5:0] IRQ_EDGE_MASK = 6'b000000,
  parameter int         COUNT_DIV     = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic [63:0]        rd_data,
  output logic [63:0]        EPC,
  output logic               takenHandler,
  output logic               timer_irq,
  input  logic [63:0]        wr_data,
  input  logic [4:0]         regnum,
  input  logic [2:0]         sel,
  input  logic [63:0]        curr_pc,
  input  logic [31:0]        instr,
  input  logic               MTC0,
  input  logic               ERET,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               overflow,
  input  logic               reserved_inst,
  input  logic               syscall,
  input  logic               break_,
  input  logic               addr_err_ld,
  input  logic               addr_err_st,
  input  logic [63:0]        bad_vaddr
);

  logic [7:0]         status_im;
  logic               status_erl, status_exl, status_ie;
  exc_code_t          exc_code;
  logic [1:0]         sw_ip;
  logic [NUM_IRQ-1:0] irq_prev, edge_ip, edge_ip_next, rising;
  logic [5:0]         hw_ip;
  logic [7:0]         cause_ip, pending;

  logic [31:0] count, compare, bad_instr;
  logic [63:0] bad_vaddr_q, epc_d;
  logic        ti;

  logic        any_flag, take_exc, take_int, addr_err_entry;
  exc_code_t   exc_sel, handler_code;
  logic        wr_ok, wr_status, wr_cause, wr_epc, wr_count, wr_compare;

  // Interrupt pending vector.
  assign rising = irq_in & ~irq_prev;

  always_comb begin
    hw_ip = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      hw_ip[i] = IRQ_EDGE_MASK[i] ? edge_ip[i] : irq_in[i];
  end

  assign cause_ip  = {hw_ip[5] | ti, hw_ip[4:0], sw_ip};
  assign pending   = cause_ip & status_im;
  assign timer_irq = ti;

  // Arbitration. ERET squashes any exception flag raised alongside it.
  assign any_flag = addr_err_ld | addr_err_st | overflow | reserved_inst | syscall | break_;
  assign take_exc = any_flag && !ERET;
  assign exc_sel  = exc_priority(addr_err_ld, addr_err_st, overflow,
                                 reserved_inst, syscall, break_);
  assign take_int = (|pending) && status_ie && !status_erl && !status_exl && !take_exc;
  assign takenHandler   = (take_exc || take_int) && !status_exl;
  assign handler_code   = take_exc ? exc_sel : INT;
  assign addr_err_entry = takenHandler && take_exc && (exc_sel == ADEL || exc_sel == ADES);

  // MTC0 decode; the write is dropped when the instruction is squashed.
  assign wr_ok      = MTC0 && !takenHandler && (sel == SEL_MAIN);
  assign wr_status  = wr_ok && (regnum == REG_STATUS);
  assign wr_cause   = wr_ok && (regnum == REG_CAUSE);
  assign wr_epc     = wr_ok && (regnum == REG_EPC);
  assign wr_count   = wr_ok && (regnum == REG_COUNT);
  assign wr_compare = wr_ok && (regnum == REG_COMPARE);

  always_comb begin
    edge_ip_next = edge_ip;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (IRQ_EDGE_MASK[i]) begin
        if (wr_cause && !wr_data[CA_IP_LO + 2 + i]) edge_ip_next[i] = 1'b0;
        edge_ip_next[i] = edge_ip_next[i] | rising[i];
      end else begin
        edge_ip_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_prev <= '0;
      edge_ip  <= '0;
    end else begin
      irq_prev <= irq_in;
      edge_ip  <= edge_ip_next;
    end
  end

  // Status, software IP bits and ExcCode. Later statements take precedence.
  always_ff @(posedge clock) begin
    if (reset) begin
      status_im  <= 8'hFF;
      status_erl <= 1'b0;
      status_exl <= 1'b0;
      status_ie  <= 1'b1;
      sw_ip      <= 2'b00;
      exc_code   <= INT;
    end else begin
      if (wr_status) begin
        status_im  <= wr_data[ST_IM_LO +: 8];
        status_erl <= wr_data[ST_ERL];
        status_exl <= wr_data[ST_EXL];
        status_ie  <= wr_data[ST_IE];
      end
      if (wr_cause) sw_ip <= wr_data[CA_IP_LO +: 2];
      if (ERET) begin
        if (status_exl) begin
          status_exl <= 1'b0;
          exc_code   <= INT;
        end else begin
          status_erl <= 1'b0;
        end
      end
      if (takenHandler) begin
        status_exl <= 1'b1;
        exc_code   <= handler_code;
      end
    end
  end

  mux2v #(.WIDTH(64)) u_epc_mux (
    .sel (takenHandler),
    .a   (wr_data),
    .b   (curr_pc),
    .out (epc_d)
  );

  register #(.WIDTH(64)) u_epc (
    .clock  (clock),
    .reset  (reset),
    .enable (takenHandler | wr_epc),
    .d      (epc_d),
    .q      (EPC)
  );

  register #(.WIDTH(64)) u_badvaddr (
    .clock  (clock),
    .reset  (reset),
    .enable (addr_err_entry),
    .d      (bad_vaddr),
    .q      (bad_vaddr_q)
  );

  register #(.WIDTH(32)) u_badinstr (
    .clock  (clock),
    .reset  (reset),
    .enable (takenHandler && take_exc),
    .d      (instr),
    .q      (bad_instr)
  );

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .wr_data    (wr_data[31:0]),
    .wr_count   (wr_count),
    .wr_compare (wr_compare),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_comb begin
    rd_data = '0;
    if (sel == SEL_MAIN) begin
      case (regnum)
        REG_BADVADDR: rd_data = bad_vaddr_q;
        REG_COUNT:    rd_data = {32'b0, count};
        REG_COMPARE:  rd_data = {32'b0, compare};
        REG_STATUS:   rd_data = {48'b0, status_im, 5'b0, status_erl, status_exl, status_ie};
        REG_CAUSE:    rd_data = {32'b0, 1'b0, ti, 14'b0, cause_ip, 1'b0, exc_code, 2'b0};
        REG_EPC:      rd_data = EPC;
        default:      rd_data = '0;
      endcase
    end else if (regnum == REG_BADVADDR && sel == SEL_BADINSTR) begin
      rd_data = {32'b0, bad_instr};
    end
  end

endmodule

// File: tb/tb_cp0_v2.sv
// Scoreboard bench for cp0_v2: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_v2;
  import cp0_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] rd_data, EPC, wr_data, curr_pc, bad_vaddr;
  logic        takenHandler, timer_irq;
  logic [4:0]  regnum;
  logic [2:0]  sel;
  logic [31:0] instr;
  logic        MTC0, ERET;
  logic [5:0]  irq_in;
  logic        overflow, reserved_inst, syscall, break_, addr_err_ld, addr_err_st;

  cp0_v2 #(.NUM_IRQ(6), .IRQ_EDGE_MASK(6'b000001), .COUNT_DIV(2)) dut (
    .clock(clock), .reset(reset), .rd_data(rd_data), .EPC(EPC),
    .takenHandler(takenHandler), .timer_irq(timer_irq), .wr_data(wr_data),
    .regnum(regnum), .sel(sel), .curr_pc(curr_pc), .instr(instr),
    .MTC0(MTC0), .ERET(ERET), .irq_in(irq_in), .overflow(overflow),
    .reserved_inst(reserved_inst), .syscall(syscall), .break_(break_),
    .addr_err_ld(addr_err_ld), .addr_err_st(addr_err_st), .bad_vaddr(bad_vaddr)
  );

  always #5 clock = ~clock;

  typedef enum int {SIG_RD, SIG_TH, SIG_EPC, SIG_TI} sig_t;
  typedef struct {
    string       name;
    sig_t        sig;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  task automatic check(input string name, input sig_t sig, input logic [63:0] exp);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin : monitor
    exp_t        e;
    logic [63:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sig)
        SIG_RD:  act = rd_data;
        SIG_TH:  act = {63'b0, takenHandler};
        SIG_EPC: act = EPC;
        default: act = {63'b0, timer_irq};
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  initial begin : watchdog
    #100000;
    if (!done) begin
      n_bad++;
      $display("FAIL watchdog: stimulus did not finish within the time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_flags();
    overflow = 0; reserved_inst = 0; syscall = 0; break_ = 0;
    addr_err_ld = 0; addr_err_st = 0; MTC0 = 0; ERET = 0;
  endtask

  task automatic rd(input string name, input logic [4:0] r, input logic [2:0] s,
                    input logic [63:0] exp);
    regnum = r;
    sel    = s;
    check(name, SIG_RD, exp);
    step(1);
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [63:0] data);
    regnum = r; sel = 3'd0; wr_data = data; MTC0 = 1;
    step(1);
    MTC0 = 0;
  endtask

  task automatic eret();
    ERET = 1;
    step(1);
    ERET = 0;
  endtask

  initial begin
    reset = 1; wr_data = '0; regnum = '0; sel = '0; curr_pc = '0; instr = '0;
    irq_in = '0; bad_vaddr = '0;
    clear_flags();
    step(2);
    reset = 0;

    // Reset state
    rd("status_reset", REG_STATUS, 3'd0, 64'h0000_FF01);
    rd("compare_reset", REG_COMPARE, 3'd0, 64'hFFFF_FFFF);
    rd("cause_reset", REG_CAUSE, 3'd0, 64'h0);
    rd("unmapped_read", REG_STATUS, 3'd1, 64'h0);
    check("th_idle", SIG_TH, 64'h0);
    step(1);

    // Overflow beats syscall
    curr_pc = 64'h40_0100; instr = 32'h0180_0020; overflow = 1; syscall = 1;
    check("th_ov", SIG_TH, 64'h1);
    step(1);
    clear_flags();
    check("epc_ov", SIG_EPC, 64'h40_0100);
    rd("cause_ov", REG_CAUSE, 3'd0, 64'h30);
    rd("status_exl", REG_STATUS, 3'd0, 64'hFF03);
    rd("badinstr_ov", REG_BADVADDR, 3'd1, 64'h0180_0020);
    reserved_inst = 1;
    check("th_nested", SIG_TH, 64'h0);
    step(1);
    clear_flags();
    rd("cause_nested", REG_CAUSE, 3'd0, 64'h30);
    eret();
    rd("status_eret", REG_STATUS, 3'd0, 64'hFF01);
    rd("cause_eret", REG_CAUSE, 3'd0, 64'h0);

    // Edge line 0, level line 1, with interrupts disabled
    mtc0(REG_STATUS, 64'hFF00);
    irq_in = 6'b000001;
    step(1);
    irq_in = 6'b000000;
    rd("ip2_latched", REG_CAUSE, 3'd0, 64'h400);
    rd("ip2_sticky", REG_CAUSE, 3'd0, 64'h400);
    irq_in = 6'b000010;
    rd("ip3_level", REG_CAUSE, 3'd0, 64'hC00);
    irq_in = 6'b000000;
    rd("ip3_dropped", REG_CAUSE, 3'd0, 64'h400);
    mtc0(REG_CAUSE, 64'h300);
    check("th_ie_off", SIG_TH, 64'h0);
    rd("ip2_cleared", REG_CAUSE, 3'd0, 64'h300);
    mtc0(REG_CAUSE, 64'h0);
    mtc0(REG_STATUS, 64'hFF01);

    // Timer: Count=10, Compare=13, divide-by-2 -> match 6 edges after the write
    mtc0(REG_COMPARE, 64'd13);
    mtc0(REG_COUNT, 64'd10);
    check("ti_early", SIG_TI, 64'h0);
    step(5);
    check("ti_edge5", SIG_TI, 64'h0);
    step(1);
    curr_pc = 64'h50_0000;
    check("ti_edge6", SIG_TI, 64'h1);
    check("th_timer", SIG_TH, 64'h1);
    rd("count_match", REG_COUNT, 3'd0, 64'd13);
    check("epc_timer", SIG_EPC, 64'h50_0000);
    rd("cause_timer", REG_CAUSE, 3'd0, 64'h4000_8000);
    mtc0(REG_COMPARE, 64'hFFFF_FFFF);
    check("ti_cleared", SIG_TI, 64'h0);
    step(1);
    eret();

    // MTC0 EPC squashed by break
    curr_pc = 64'h60_0040; break_ = 1;
    regnum = REG_EPC; sel = 3'd0; wr_data = 64'hDEAD; MTC0 = 1;
    check("th_break", SIG_TH, 64'h1);
    step(1);
    clear_flags();
    check("epc_break", SIG_EPC, 64'h60_0040);
    rd("cause_break", REG_CAUSE, 3'd0, 64'h24);
    eret();

    // Reserved instruction beats break
    reserved_inst = 1; break_ = 1;
    step(1);
    clear_flags();
    rd("cause_ri", REG_CAUSE, 3'd0, 64'h28);
    eret();

    // Store address error
    curr_pc = 64'h70_0000; bad_vaddr = 64'h1003; addr_err_st = 1;
    check("th_ades", SIG_TH, 64'h1);
    step(1);
    clear_flags();
    rd("badvaddr_ades", REG_BADVADDR, 3'd0, 64'h1003);
    rd("cause_ades", REG_CAUSE, 3'd0, 64'h14);
    eret();

    // Reset concurrent with handler entry
    overflow = 1; reset = 1;
    step(1);
    clear_flags();
    reset = 0;
    rd("count_rst", REG_COUNT, 3'd0, 64'h0);
    check("epc_rst", SIG_EPC, 64'h0);
    rd("status_rst", REG_STATUS, 3'd0, 64'hFF01);
    rd("cause_rst", REG_CAUSE, 3'd0, 64'h0);
    rd("badvaddr_rst", REG_BADVADDR, 3'd0, 64'h0);
    rd("badinstr_rst", REG_BADVADDR, 3'd1, 64'h0);
    rd("compare_rst", REG_COMPARE, 3'd0, 64'hFFFF_FFFF);

    step(1);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectation(s) never compared", sb.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
